// File: rtl/alu_flag_cond_unit_pkg.sv
// Shared types for the ALU flag/condition unit: condition codes, flag bundle,
// query FSM states and the ARM-style condition evaluator.
package alu_pkg;

   typedef enum logic [3:0] {
      COND_EQ = 4'd0,
      COND_NE = 4'd1,
      COND_CS = 4'd2,
      COND_CC = 4'd3,
      COND_MI = 4'd4,
      COND_PL = 4'd5,
      COND_VS = 4'd6,
      COND_VC = 4'd7,
      COND_HI = 4'd8,
      COND_LS = 4'd9,
      COND_GE = 4'd10,
      COND_LT = 4'd11,
      COND_GT = 4'd12,
      COND_LE = 4'd13,
      COND_AL = 4'd14,
      COND_NV = 4'd15
   } cond_t;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } flags_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   function automatic logic cond_eval(cond_t cond, flags_t f);
      logic r;
      r = 1'b0;
      case (cond)
         COND_EQ: r = f.z;
         COND_NE: r = ~f.z;
         COND_CS: r = f.c;
         COND_CC: r = ~f.c;
         COND_MI: r = f.n;
         COND_PL: r = ~f.n;
         COND_VS: r = f.v;
         COND_VC: r = ~f.v;
         COND_HI: r = f.c & ~f.z;
         COND_LS: r = ~f.c | f.z;
         COND_GE: r = (f.n == f.v);
         COND_LT: r = (f.n != f.v);
         COND_GT: r = ~f.z & (f.n == f.v);
         COND_LE: r = f.z | (f.n != f.v);
         COND_AL: r = 1'b1;
         COND_NV: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/alu_flag_cond_unit_if.sv
// ALU status update, condition query and response handshake bundle.
// master = ALU/branch side driving updates and queries; slave = the flag unit.
interface alu_flag_cond_unit_if #(
   parameter int N = 4
);
   logic         upd_valid;
   logic [N-1:0] upd_rslt;
   logic         upd_z;
   logic         upd_n;
   logic         upd_c;
   logic         upd_ov;
   logic         q_valid;
   logic         q_ready;
   logic [3:0]   q_cond;
   logic         resp_valid;
   logic         resp_ready;
   logic         resp_taken;

   modport master (
      output upd_valid, upd_rslt, upd_z, upd_n, upd_c, upd_ov,
      output q_valid, q_cond, resp_ready,
      input  q_ready, resp_valid, resp_taken
   );

   modport slave (
      input  upd_valid, upd_rslt, upd_z, upd_n, upd_c, upd_ov,
      input  q_valid, q_cond, resp_ready,
      output q_ready, resp_valid, resp_taken
   );
endinterface

// File: rtl/alu_flag_cond_unit_cond_eval.sv
// Combinational condition-code evaluator wrapping alu_pkg::cond_eval.
module alu_cond_eval
   import alu_pkg::*;
(
   input  cond_t  cond,
   input  flags_t flags,
   output logic   taken
);

   assign taken = cond_eval(cond, flags);

endmodule

// File: rtl/alu_flag_cond_unit.sv
// Flag/status register, overflow tracking and condition-query FSM.
// Optional FLAG_FORWARD_EN: evaluate against incoming flags on a same-cycle update.
module alu_flag_cond_unit
   import alu_pkg::*;
#(
   parameter int N     = 4,
   parameter int CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   alu_flag_cond_unit_if.slave  bus,
   input  logic                 clr_sticky,
   output logic [N-1:0]         rslt_q,
   output logic [3:0]           nzcv,
   output logic [CNT_W-1:0]     ov_count,
   output logic                 ov_sticky
);

   state_t state, state_n;
   cond_t  cond_q, cond_n;
   logic   taken_q, taken_n;
   flags_t flags_q;
   flags_t upd_flags;
   cond_t  eval_cond;
   logic   reg_taken;

   assign upd_flags = '{n: bus.upd_n, z: bus.upd_z, c: bus.upd_c, v: bus.upd_ov};

   // In IDLE the live query code is evaluated; in WAIT the latched one is.
   assign eval_cond = (state == ST_IDLE) ? cond_t'(bus.q_cond) : cond_q;

   alu_cond_eval u_eval_reg (
      .cond  (eval_cond),
      .flags (flags_q),
      .taken (reg_taken)
   );

`ifdef FLAG_FORWARD_EN
   logic fwd_taken;

   alu_cond_eval u_eval_fwd (
      .cond  (cond_t'(bus.q_cond)),
      .flags (upd_flags),
      .taken (fwd_taken)
   );
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rslt_q  <= '0;
         flags_q <= '0;
      end else if (bus.upd_valid) begin
         rslt_q  <= bus.upd_rslt;
         flags_q <= upd_flags;
      end
   end

   assign nzcv = flags_q;

   // An overflow update in the same cycle as a clear wins: count restarts at 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ov_count  <= '0;
         ov_sticky <= 1'b0;
      end else if (bus.upd_valid && bus.upd_ov) begin
         ov_sticky <= 1'b1;
         if (clr_sticky)
            ov_count <= CNT_W'(1);
         else if (ov_count != {CNT_W{1'b1}})
            ov_count <= ov_count + CNT_W'(1);
      end else if (clr_sticky) begin
         ov_count  <= '0;
         ov_sticky <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         cond_q  <= COND_EQ;
         taken_q <= 1'b0;
      end else begin
         state   <= state_n;
         cond_q  <= cond_n;
         taken_q <= taken_n;
      end
   end

   always_comb begin
      state_n = state;
      cond_n  = cond_q;
      taken_n = taken_q;
      case (state)
         ST_IDLE: begin
            if (bus.q_valid) begin
               cond_n = cond_t'(bus.q_cond);
               if (bus.upd_valid) begin
`ifdef FLAG_FORWARD_EN
                  taken_n = fwd_taken;
                  state_n = ST_RESP;
`else
                  state_n = ST_WAIT;
`endif
               end else begin
                  taken_n = reg_taken;
                  state_n = ST_RESP;
               end
            end
         end
         ST_WAIT: begin
            taken_n = reg_taken;
            state_n = ST_RESP;
         end
         ST_RESP: begin
            if (bus.resp_ready)
               state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   assign bus.q_ready    = (state == ST_IDLE);
   assign bus.resp_valid = (state == ST_RESP);
   assign bus.resp_taken = (state == ST_RESP) & taken_q;

endmodule

// File: tb/tb_alu_flag_cond_unit.sv
// Self-checking bench for alu_flag_cond_unit (CNT_W=2 to reach saturation quickly).
// Honours FLAG_FORWARD_EN for the same-cycle update/query latency.
module tb_alu_flag_cond_unit;

   localparam int N     = 4;
   localparam int CNT_W = 2;
   localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef FLAG_FORWARD_EN
   localparam int FWD_LAT = 1;
`else
   localparam int FWD_LAT = 2;
`endif

   logic             clk;
   logic             rst_n;
   logic             clr_sticky;
   logic [N-1:0]     rslt_q;
   logic [3:0]       nzcv;
   logic [CNT_W-1:0] ov_count;
   logic             ov_sticky;

   alu_flag_cond_unit_if #(.N(N)) bus ();

   alu_flag_cond_unit #(.N(N), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .clr_sticky (clr_sticky),
      .rslt_q     (rslt_q),
      .nzcv       (nzcv),
      .ov_count   (ov_count),
      .ov_sticky  (ov_sticky)
   );

   typedef struct {
      logic [3:0] cond;
      logic [3:0] flags;
      logic       exp_taken;
   } vec_t;

   int         checks = 0;
   int         errors = 0;
   logic       exp_q[$];
   vec_t       vecs[$];
   logic [3:0] m_nzcv;
   logic [N-1:0] m_rslt;
   int         m_cnt;
   logic       m_sticky;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Independent reference: pairs of codes share a base term, odd codes invert it.
   function automatic logic model_cond(input logic [3:0] code, input logic [3:0] f);
      logic n, z, c, v, base;
      n = f[3]; z = f[2]; c = f[1]; v = f[0];
      if (code == 4'd14) return 1'b1;
      if (code == 4'd15) return 1'b0;
      case (code[3:1])
         3'd0:    base = z;
         3'd1:    base = c;
         3'd2:    base = n;
         3'd3:    base = v;
         3'd4:    base = c & ~z;
         3'd5:    base = ~(n ^ v);
         3'd6:    base = ~z & ~(n ^ v);
         default: base = 1'b0;
      endcase
      return base ^ code[0];
   endfunction

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_upd(input logic valid, input logic [3:0] f, input logic [N-1:0] r, input logic ov);
      bus.upd_valid = valid;
      bus.upd_n     = f[3];
      bus.upd_z     = f[2];
      bus.upd_c     = f[1];
      bus.upd_ov    = f[0] | ov;
      bus.upd_rslt  = r;
   endtask

   // One-cycle status update (or bare clear when upd=0), then status checks.
   task automatic apply_stimulus(input logic upd, input logic [3:0] f, input logic [N-1:0] r,
                                 input logic ov, input logic clr);
      drive_upd(upd, f, r, ov);
      clr_sticky = clr;
      step();
      drive_upd(1'b0, 4'h0, '0, 1'b0);
      clr_sticky = 1'b0;
      if (upd) begin
         m_nzcv = {f[3:1], f[0] | ov};
         m_rslt = r;
      end
      if (upd && (f[0] | ov)) begin
         m_cnt    = clr ? 1 : ((m_cnt < CMAX) ? m_cnt + 1 : CMAX);
         m_sticky = 1'b1;
      end else if (clr) begin
         m_cnt    = 0;
         m_sticky = 1'b0;
      end
      check_output("nzcv", nzcv, m_nzcv);
      check_output("rslt_q", rslt_q, m_rslt);
      check_output("ov_count", ov_count, m_cnt);
      check_output("ov_sticky", ov_sticky, m_sticky);
   endtask

   // Bounded wait for a response, then scoreboard compare and handshake.
   task automatic wait_resp(input int start_lat, input int exp_lat, input string name);
      int   lat;
      logic exp;
      lat = start_lat;
      while (!bus.resp_valid && lat < 8) begin
         step();
         lat++;
      end
      check_output($sformatf("%s latency", name), lat, exp_lat);
      exp = exp_q.pop_front();
      if (bus.resp_valid) begin
         check_output($sformatf("%s resp_taken", name), bus.resp_taken, exp);
         bus.resp_ready = 1'b1;
         step();
         bus.resp_ready = 1'b0;
         check_output($sformatf("%s resp_valid after handshake", name), bus.resp_valid, 1'b0);
         check_output($sformatf("%s q_ready after handshake", name), bus.q_ready, 1'b1);
      end
   endtask

   task automatic run_query(input logic [3:0] cond, input logic exp_taken, input int exp_lat,
                            input logic with_upd, input logic [3:0] f, input string name);
      check_output($sformatf("%s q_ready idle", name), bus.q_ready, 1'b1);
      bus.q_valid = 1'b1;
      bus.q_cond  = cond;
      if (with_upd) drive_upd(1'b1, f, '0, 1'b0);
      exp_q.push_back(exp_taken);
      step();
      bus.q_valid = 1'b0;
      drive_upd(1'b0, 4'h0, '0, 1'b0);
      if (with_upd) begin
         m_nzcv = f;
         m_rslt = '0;
      end
      check_output($sformatf("%s q_ready busy", name), bus.q_ready, 1'b0);
      wait_resp(1, exp_lat, name);
   endtask

   initial begin
      rst_n          = 1'b0;
      clr_sticky     = 1'b0;
      bus.q_valid    = 1'b0;
      bus.q_cond     = 4'h0;
      bus.resp_ready = 1'b0;
      drive_upd(1'b0, 4'h0, '0, 1'b0);
      m_nzcv = 4'h0; m_rslt = '0; m_cnt = 0; m_sticky = 1'b0;
      #12;
      check_output("reset q_ready", bus.q_ready, 1'b1);
      check_output("reset resp_valid", bus.resp_valid, 1'b0);
      check_output("reset nzcv", nzcv, 4'h0);
      rst_n = 1'b1;
      step();

      // Reset in the middle of a pending response
      apply_stimulus(1'b1, 4'b1111, 4'h5, 1'b1, 1'b0);
      bus.q_valid = 1'b1;
      bus.q_cond  = 4'd14;
      step();
      bus.q_valid = 1'b0;
      check_output("pre-reset resp_valid", bus.resp_valid, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check_output("mid reset resp_valid", bus.resp_valid, 1'b0);
      check_output("mid reset resp_taken", bus.resp_taken, 1'b0);
      check_output("mid reset q_ready", bus.q_ready, 1'b1);
      check_output("mid reset nzcv", nzcv, 4'h0);
      check_output("mid reset rslt_q", rslt_q, 4'h0);
      check_output("mid reset ov_count", ov_count, 0);
      check_output("mid reset ov_sticky", ov_sticky, 1'b0);
      m_nzcv = 4'h0; m_rslt = '0; m_cnt = 0; m_sticky = 1'b0;
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check_output("post reset no stray resp", bus.resp_valid, 1'b0);
      end

      // Zero result: EQ taken, NE not
      apply_stimulus(1'b1, 4'b0100, 4'h0, 1'b0, 1'b0);
      run_query(4'd0, 1'b1, 1, 1'b0, 4'h0, "EQ z=1");
      run_query(4'd1, 1'b0, 1, 1'b0, 4'h0, "NE z=1");

      // N=1,V=0: LT taken; GE held off while flags change underneath
      apply_stimulus(1'b1, 4'b1000, 4'h9, 1'b0, 1'b0);
      run_query(4'd11, 1'b1, 1, 1'b0, 4'h0, "LT n=1");
      bus.q_valid = 1'b1;
      bus.q_cond  = 4'd10;
      exp_q.push_back(1'b0);
      step();
      bus.q_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive_upd(1'b1, 4'b0000, 4'h3, 1'b0);
         check_output("GE hold resp_valid", bus.resp_valid, 1'b1);
         check_output("GE hold resp_taken", bus.resp_taken, 1'b0);
         step();
      end
      drive_upd(1'b0, 4'h0, '0, 1'b0);
      m_nzcv = 4'b0000; m_rslt = 4'h3;
      check_output("GE hold nzcv updated", nzcv, m_nzcv);
      wait_resp(1, 1, "GE held");

      // Query in the same cycle as an update
      apply_stimulus(1'b1, 4'b0000, 4'h1, 1'b0, 1'b0);
      run_query(4'd2, 1'b1, FWD_LAT, 1'b1, 4'b0010, "CS with update");
      bus.q_valid = 1'b1;
      bus.q_cond  = 4'd3;
      drive_upd(1'b1, 4'b0010, '0, 1'b0);
      exp_q.push_back(1'b0);
      step();
      bus.q_valid = 1'b0;
      drive_upd(1'b1, 4'b0000, '0, 1'b0);
      step();
      drive_upd(1'b0, 4'h0, '0, 1'b0);
      m_nzcv = 4'b0000; m_rslt = '0;
      check_output("CC late update nzcv", nzcv, m_nzcv);
      wait_resp(2, 2, "CC late update ignored");

      // Overflow counter saturation and sticky clear
      for (int i = 0; i < 5; i++)
         apply_stimulus(1'b1, 4'b0001, 4'(i), 1'b1, 1'b0);
      check_output("ov_count saturated", ov_count, CMAX);
      apply_stimulus(1'b1, 4'b0001, 4'h7, 1'b1, 1'b1);
      apply_stimulus(1'b0, 4'h0, '0, 1'b0, 1'b1);

      // Full sweep of codes over flag combinations
      for (int f = 0; f < 16; f++) begin
         for (int c = 0; c < 16; c++) begin
            vec_t v;
            v.cond      = 4'(c);
            v.flags     = 4'(f);
            v.exp_taken = model_cond(4'(c), 4'(f));
            vecs.push_back(v);
         end
      end
      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].flags != m_nzcv)
            apply_stimulus(1'b1, vecs[i].flags, vecs[i].flags, 1'b0, 1'b0);
         run_query(vecs[i].cond, vecs[i].exp_taken, 1, 1'b0, 4'h0,
                   $sformatf("sweep c=%0d f=%0h", vecs[i].cond, vecs[i].flags));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_flag_cond_unit.md
Name: alu_flag_cond_unit

Overview:
- Consumer side of the ALU status interface: captures each ALU result and its Z/N/C/V flags into a status register.
- Answers condition-code queries (16 ARM-style codes) over a valid/ready request and response handshake.
- Keeps a saturating overflow-event counter and a sticky overflow bit.
- Sits between the ALU and the branch/predication logic of the datapath.

Parameters:
N, 4, ALU result width; must match the ALU's N.
CNT_W, 8, width of the overflow-event counter.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
upd_valid  in  1  ALU result/flags valid this cycle; always accepted, no backpressure.
upd_rslt  in  N  ALU result.
upd_z, upd_n, upd_c, upd_ov  in  1 each  ALU zero/negative/carry/overflow flags.
q_valid  in  1  condition query valid.
q_ready  out  1  unit can accept a query.
q_cond  in  4  condition code.
resp_valid  out  1  response valid.
resp_ready  in  1  downstream accepts the response.
resp_taken  out  1  condition result.
rslt_q  out  N  last captured result.
nzcv  out  4  registered flags {N,Z,C,V}.
ov_count  out  CNT_W  saturating count of updates with upd_ov=1.
ov_sticky  out  1  set by any overflow, held until cleared.
clr_sticky  in  1  synchronous clear of ov_sticky and ov_count.

Behaviour:
- Reset (async, rst_n=0): rslt_q=0, nzcv=0, ov_count=0, ov_sticky=0, resp_valid=0, resp_taken=0, q_ready=1, FSM=IDLE. Reset mid-query drops the query; no response is produced.
- Status register: on upd_valid, rslt_q and nzcv load at the next edge; otherwise they hold.
- Condition codes:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
  - 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V).
  - 14 AL 1; 15 NV 0.
- FSM states IDLE, WAIT, RESP. q_ready=1 only in IDLE.
- IDLE:
  - Query accepted on q_valid&q_ready; q_cond is latched.
  - No upd_valid in the accept cycle: evaluate against nzcv, go to RESP; resp_valid rises 1 cycle after accept.
  - upd_valid in the accept cycle: go to WAIT. Evaluation then uses the newly loaded flags and the response comes 2 cycles after accept.
- WAIT: evaluate on the now-updated nzcv, go to RESP. An upd_valid during WAIT is ignored for this query; evaluation uses the flags registered at WAIT entry.
- RESP:
  - resp_valid=1; resp_taken stays stable until resp_ready.
  - On resp_ready go to IDLE; q_ready returns next cycle, so there is no back-to-back accept.
  - Flag updates in RESP do not alter resp_taken.
- Overflow tracking, on upd_valid&upd_ov:
  - ov_count increments and saturates at 2^CNT_W-1 (no wrap).
  - ov_sticky is set.
- clr_sticky:
  - Alone: ov_sticky=0, ov_count=0.
  - Same cycle as an overflow update: ov_sticky=1 and ov_count=1 (set wins over clear).

Optional Feature:
Macro FLAG_FORWARD_EN.
- Defined: on a query accept with upd_valid in the same cycle, the condition is evaluated on the incoming upd_n/z/c/ov flags and the FSM goes directly to RESP. Latency is always 1 cycle and WAIT is unreachable.
- Undefined: WAIT path as described; latency is 1 or 2 cycles.

Decomposition:
- Shared package alu_pkg:
  - cond_t enum (EQ..NV, 4-bit).
  - flags_t packed struct {n,z,c,v}.
  - fsm state enum.
  - Function cond_eval(cond_t, flags_t) returning bit.
- One natural sub-module: alu_cond_eval, a combinational wrapper around cond_eval, instantiated once for the registered flags and, under FLAG_FORWARD_EN, once for the forwarded flags.

Test Plan:
1. Reset with rst_n=0 mid-RESP -> all outputs 0, q_ready=1; release reset, no stray resp_valid.
2. Update with upd_rslt=4'h0, Z=1 (others 0); next cycle query EQ -> resp_taken=1 one cycle after accept; query NE -> 0.
3. Flags N=1, V=0; query GE -> resp_taken=0, LT -> 1; hold resp_ready=0 for 3 cycles while sending an update with N=0 -> resp_valid and resp_taken unchanged until handshake.
4. Query CS in the same cycle as an update with C=1 (old C=0):
   - Without FLAG_FORWARD_EN: response after 2 cycles, resp_taken=1.
   - With it: response after 1 cycle, resp_taken=1.
5. CNT_W=2: five updates with upd_ov=1 -> ov_count=3 (saturated), ov_sticky=1; clr_sticky together with an overflow update -> ov_count=1, ov_sticky=1; clr_sticky alone -> both 0.
6. All 16 codes swept over all 16 NZCV combinations -> resp_taken matches a cond_eval model; NV always 0, AL always 1.
